// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: operation codes, FSM states and the
// carry-seed helper used when an operation is accepted.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // SUB is A + ~B + 1, so its carry chain is seeded with 1.
  function automatic logic effective_carry(input alu_op_t op, input logic carry_in);
    case (op)
      ALU_ADD: effective_carry = carry_in;
      ALU_SUB: effective_carry = 1'b1;
      default: effective_carry = 1'b0;
    endcase
  endfunction

  function automatic logic is_arith(input alu_op_t op);
    is_arith = (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: AND, OR or full add. SUB reaches this slice as an ADD
// with B already inverted by the caller.
module alu_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_t op,
  output logic    res,
  output logic    cout
);

  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      default: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are shifted LSB-first through one alu_slice, one
// bit per clock, and the result/flags are registered when the last bit lands.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  alu_op_t          op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output state_t           state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: an operation is accepted on a rising edge where start=1 and
  // ready=1; done pulses for exactly one cycle when result/flags update.
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  alu_op_t          op_q;
  logic             carry_q;

  logic             accept;
  logic             last_bit;
  logic             slice_b;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next;

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign slice_b  = b_sr[0] ^ (op_q == ALU_SUB);
  assign res_next = {slice_res, res_sr[WIDTH-1:1]};

  alu_slice u_slice (
    .a    (a_sr[0]),
    .b    (slice_b),
    .cin  (carry_q),
    .op   (op_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand/result shift datapath and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      op_q    <= ALU_AND;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_sr    <= a;
      b_sr    <= b;
      res_sr  <= '0;
      op_q    <= op;
      carry_q <= effective_carry(op, carry_in);
    end else if (state == S_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_next;
      carry_q <= slice_cout;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // On the last bit carry_q holds the carry into the MSB, which together
  // with the slice carry-out gives signed overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (state == S_RUN && last_bit) begin
      result    <= res_next;
      carry_out <= is_arith(op_q) ? slice_cout : 1'b0;
      overflow  <= is_arith(op_q) ? (carry_q ^ slice_cout) : 1'b0;
      zero      <= (res_next == '0);
    end
  end

endmodule
